tempo_selector: RTL and testbench

Tempo decision stage directly downstream of the audio processing unit. Integrates the magnitude of each of the six comb-filter outputs (60/90/120/180/210/240 BPM) over a fixed window of audio samples. At each window end it picks the strongest tempo and publishes its BPM, index and a confidence byte with a one-cycle valid strobe. Accumulation never stops: a new window starts on the sample immediately after the previous one closes, and no samples are lost while the decision is computed.

---
 rtl/tempo_selector_if.sv | 25 ++
 rtl/tempo_selector.sv | 146 ++++++++++++++
 tb/tb_tempo_selector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tempo_selector_if.sv
// Sample/decision bus between the comb stage and the tempo selector.
// The master drives the sample strobe and comb outputs; the slave publishes decisions.
interface tempo_selector_if;
  logic              ready;
  logic signed [7:0] comb60;
  logic signed [7:0] comb90;
  logic signed [7:0] comb120;
  logic signed [7:0] comb180;
  logic signed [7:0] comb210;
  logic signed [7:0] comb240;
  logic        [7:0] tempo_bpm;
  logic        [2:0] tempo_idx;
  logic        [7:0] confidence;
  logic              tempo_valid;

  modport master (
    output ready, comb60, comb90, comb120, comb180, comb210, comb240,
    input  tempo_bpm, tempo_idx, confidence, tempo_valid
  );

  modport slave (
    input  ready, comb60, comb90, comb120, comb180, comb210, comb240,
    output tempo_bpm, tempo_idx, confidence, tempo_valid
  );
endinterface

// File: rtl/tempo_selector.sv
// Integrates comb-filter magnitudes over a sample window and publishes the strongest tempo.
// Live accumulation never pauses; the winner search runs on a snapshot of the closed window.
module tempo_selector #(
  parameter int WINDOW = 1024,
  parameter int ACC_W  = 20
) (
  input  logic            clk,
  input  logic            reset,
  tempo_selector_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_PUBLISH} state_t;

  state_t             r_state, w_state_nxt;
  logic signed [7:0]  w_comb [0:5];
  logic [ACC_W-1:0]   w_sum  [0:5];
  logic [ACC_W-1:0]   r_acc  [0:5];
  logic [ACC_W-1:0]   r_snap [0:5];
  logic [15:0]        r_cnt;
  logic               w_close;
  logic [2:0]         r_k;
  logic [ACC_W-1:0]   w_cur;
  logic [ACC_W-1:0]   r_best;
  logic [2:0]         r_bidx;
  logic [7:0]         r_bpm;
  logic [2:0]         r_idx;
  logic [7:0]         r_conf;
  logic               r_valid;

  // -128 must map to +128, so the negation is done in unsigned 8-bit arithmetic.
  function automatic logic [7:0] f_abs(input logic signed [7:0] x);
    f_abs = x[7] ? (~x + 8'd1) : x;
  endfunction

  function automatic logic [ACC_W-1:0] f_sat_add(input logic [ACC_W-1:0] a, input logic [7:0] m);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(m);
    f_sat_add = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] f_bpm(input logic [2:0] idx);
    case (idx)
      3'd0:    f_bpm = 8'd60;
      3'd1:    f_bpm = 8'd90;
      3'd2:    f_bpm = 8'd120;
      3'd3:    f_bpm = 8'd180;
      3'd4:    f_bpm = 8'd210;
      3'd5:    f_bpm = 8'd240;
      default: f_bpm = 8'd0;
    endcase
  endfunction

  assign w_comb[0] = bus.comb60;
  assign w_comb[1] = bus.comb90;
  assign w_comb[2] = bus.comb120;
  assign w_comb[3] = bus.comb180;
  assign w_comb[4] = bus.comb210;
  assign w_comb[5] = bus.comb240;

  assign w_close = bus.ready && (r_cnt == 16'(WINDOW - 1));
  assign w_cur   = r_snap[r_k];

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_sum[i] = f_sat_add(r_acc[i], f_abs(w_comb[i]));
    end
  end

  // A close while the search is busy still clears the live window but leaves the snapshot alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        r_acc[i]  <= '0;
        r_snap[i] <= '0;
      end
      r_cnt <= '0;
    end else if (bus.ready) begin
      if (w_close) begin
        for (int i = 0; i < 6; i++) begin
          r_acc[i] <= '0;
          if (r_state == S_IDLE) r_snap[i] <= w_sum[i];
        end
        r_cnt <= '0;
      end else begin
        for (int i = 0; i < 6; i++) r_acc[i] <= w_sum[i];
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_close) w_state_nxt = S_COMPARE;
      S_COMPARE: if (r_k == 3'd5) w_state_nxt = S_PUBLISH;
      S_PUBLISH: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k     <= '0;
      r_best  <= '0;
      r_bidx  <= '0;
      r_bpm   <= '0;
      r_idx   <= '0;
      r_conf  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_COMPARE: begin
          if (r_k == 3'd0 || w_cur > r_best) begin
            r_best <= w_cur;
            r_bidx <= r_k;
          end
          r_k <= (r_k == 3'd5) ? 3'd0 : r_k + 3'd1;
        end
        S_PUBLISH: begin
          r_valid <= 1'b1;
          if (r_best == '0) begin
            r_bpm  <= 8'd0;
            r_idx  <= 3'd7;
            r_conf <= 8'd0;
          end else begin
            r_bpm  <= f_bpm(r_bidx);
            r_idx  <= r_bidx;
            r_conf <= r_best[ACC_W-1 -: 8];
          end
        end
        default: r_k <= '0;
      endcase
    end
  end

  assign bus.tempo_bpm   = r_bpm;
  assign bus.tempo_idx   = r_idx;
  assign bus.confidence  = r_conf;
  assign bus.tempo_valid = r_valid;
endmodule

// File: tb/tb_tempo_selector.sv
// Bench for tempo_selector: two instances (WINDOW 16/ACC_W 10 and WINDOW 8/ACC_W 12) share stimulus
// and are compared every cycle against a window-level reference model.
module tb_tempo_selector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tempo_selector_if if16();
  tempo_selector_if if8();

  tempo_selector #(.WINDOW(16), .ACC_W(10)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  tempo_selector #(.WINDOW(8),  .ACC_W(12)) dut8  (.clk(clk), .reset(reset), .bus(if8.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: per-window sums, argmax at close, publish 7 edges later.
  int win[2] = '{16, 8};
  int aw[2]  = '{10, 12};
  int bpm_tab[6] = '{60, 90, 120, 180, 210, 240};
  int m_acc[2][6];
  int m_cnt[2];
  bit m_busy[2];
  int m_cd[2];
  int p_bpm[2], p_idx[2], p_conf[2];
  int e_bpm[2], e_idx[2], e_conf[2];
  bit e_vld[2];

  logic rdy;
  int   c[6];
  int   q8_bpm[$];
  int   q8_idx[$];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 6; i++) m_acc[d][i] = 0;
      m_cnt[d] = 0; m_busy[d] = 0; m_cd[d] = 0;
      e_bpm[d] = 0; e_idx[d] = 0; e_conf[d] = 0; e_vld[d] = 0;
    end
  endfunction

  function automatic void model_step();
    int s[6];
    int mx, mag, best, bi;
    for (int d = 0; d < 2; d++) begin
      e_vld[d] = 0;
      if (m_busy[d]) begin
        m_cd[d]--;
        if (m_cd[d] == 0) begin
          e_bpm[d] = p_bpm[d]; e_idx[d] = p_idx[d]; e_conf[d] = p_conf[d];
          e_vld[d] = 1; m_busy[d] = 0;
        end
      end
      if (rdy) begin
        mx = (1 << aw[d]) - 1;
        for (int i = 0; i < 6; i++) begin
          mag = (c[i] < 0) ? -c[i] : c[i];
          s[i] = (m_acc[d][i] + mag > mx) ? mx : m_acc[d][i] + mag;
        end
        if (m_cnt[d] == win[d] - 1) begin
          if (!m_busy[d]) begin
            best = 0; bi = 0;
            for (int i = 0; i < 6; i++) if (s[i] > best) begin best = s[i]; bi = i; end
            if (best == 0) begin
              p_bpm[d] = 0; p_idx[d] = 7; p_conf[d] = 0;
            end else begin
              p_bpm[d] = bpm_tab[bi]; p_idx[d] = bi; p_conf[d] = (best >> (aw[d] - 8)) & 255;
            end
            m_busy[d] = 1; m_cd[d] = 7;
          end
          for (int i = 0; i < 6; i++) m_acc[d][i] = 0;
          m_cnt[d] = 0;
        end else begin
          for (int i = 0; i < 6; i++) m_acc[d][i] = s[i];
          m_cnt[d]++;
        end
      end
    end
  endfunction

  task automatic drive();
    if16.ready = rdy;
    if16.comb60 = 8'(c[0]); if16.comb90 = 8'(c[1]); if16.comb120 = 8'(c[2]);
    if16.comb180 = 8'(c[3]); if16.comb210 = 8'(c[4]); if16.comb240 = 8'(c[5]);
    if8.ready = rdy;
    if8.comb60 = 8'(c[0]); if8.comb90 = 8'(c[1]); if8.comb120 = 8'(c[2]);
    if8.comb180 = 8'(c[3]); if8.comb210 = 8'(c[4]); if8.comb240 = 8'(c[5]);
  endtask

  task automatic check_outputs();
    chk("vld16",  32'(if16.tempo_valid), 32'(e_vld[0]));
    chk("bpm16",  32'(if16.tempo_bpm),   e_bpm[0]);
    chk("idx16",  32'(if16.tempo_idx),   e_idx[0]);
    chk("conf16", 32'(if16.confidence),  e_conf[0]);
    chk("vld8",   32'(if8.tempo_valid),  32'(e_vld[1]));
    chk("bpm8",   32'(if8.tempo_bpm),    e_bpm[1]);
    chk("idx8",   32'(if8.tempo_idx),    e_idx[1]);
    chk("conf8",  32'(if8.confidence),   e_conf[1]);
  endtask

  task automatic tick();
    drive();
    if (reset) model_step();
    else       model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    if (if8.tempo_valid === 1'b1) begin
      q8_bpm.push_back(int'(if8.tempo_bpm));
      q8_idx.push_back(int'(if8.tempo_idx));
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 6; i++) c[i] = v;
  endtask

  task automatic window16(input int idle);
    rdy = 1'b1;
    repeat (16) tick();
    rdy = 1'b0;
    repeat (idle) tick();
  endtask

  task automatic reset_now(input string tag);
    reset = 1'b0;
    #2;
    model_reset();
    chk({tag, "_bpm"},  32'(if16.tempo_bpm),   0);
    chk({tag, "_idx"},  32'(if16.tempo_idx),   0);
    chk({tag, "_conf"}, 32'(if16.confidence),  0);
    chk({tag, "_vld"},  32'(if16.tempo_valid), 0);
    chk({tag, "_bpm8"}, 32'(if8.tempo_bpm),    0);
  endtask

  initial begin
    logic signed [7:0] t;
    rdy = 1'b0;
    set_all(0);
    drive();
    model_reset();
    #1;
    reset_now("rst0");
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();

    // Single winner
    set_all(10); c[2] = 50;
    window16(7);
    chk("sw_vld",  32'(if16.tempo_valid), 1);
    chk("sw_bpm",  32'(if16.tempo_bpm),   120);
    chk("sw_idx",  32'(if16.tempo_idx),   2);
    chk("sw_conf", 32'(if16.confidence),  200);
    chk("sw_snap", 32'(dut16.r_snap[2]),  800);
    tick();
    chk("sw_hold", 32'(if16.tempo_bpm),   120);

    // Tie with a negative input
    set_all(0); c[0] = -40; c[3] = 40;
    window16(7);
    chk("tie_bpm", 32'(if16.tempo_bpm), 60);
    chk("tie_idx", 32'(if16.tempo_idx), 0);

    // Silence
    set_all(0);
    window16(7);
    chk("sil_vld",  32'(if16.tempo_valid), 1);
    chk("sil_bpm",  32'(if16.tempo_bpm),   0);
    chk("sil_idx",  32'(if16.tempo_idx),   7);
    chk("sil_conf", 32'(if16.confidence),  0);
    tick();
    chk("sil_once", 32'(if16.tempo_valid), 0);

    // Back-to-back windows on the 8-sample instance
    q8_bpm.delete(); q8_idx.delete();
    rdy = 1'b1;
    set_all(0); c[5] = -128;
    repeat (8) tick();
    set_all(0); c[1] = 5;
    repeat (8) tick();
    rdy = 1'b0;
    repeat (7) tick();
    chk("b2b_cnt", 32'(q8_bpm.size()), 2);
    if (q8_bpm.size() >= 2) begin
      chk("b2b_bpm0", 32'(q8_bpm[0]), 240);
      chk("b2b_idx0", 32'(q8_idx[0]), 5);
      chk("b2b_bpm1", 32'(q8_bpm[1]), 90);
      chk("b2b_idx1", 32'(q8_idx[1]), 1);
    end

    // Saturation
    set_all(0); c[4] = 127;
    window16(7);
    chk("sat_snap", 32'(dut16.r_snap[4]), 1023);
    chk("sat_conf", 32'(if16.confidence), 255);
    chk("sat_bpm",  32'(if16.tempo_bpm),  210);

    // Reset mid-window, then quiet
    rdy = 1'b1; set_all(20);
    repeat (5) tick();
    reset_now("rst_win");
    repeat (2) tick();
    reset = 1'b1;
    rdy = 1'b0;
    repeat (20) tick();

    // Reset mid-COMPARE: the pending decision must never publish
    set_all(0); c[3] = 30;
    window16(3);
    reset_now("rst_cmp");
    repeat (2) tick();
    reset = 1'b1;
    repeat (20) tick();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 6; i++) begin
        t = 8'($urandom);
        c[i] = (n % 200 < 100) ? int'(t) >>> 3 : int'(t);
      end
      if ($urandom_range(0, 4) == 0) c[$urandom_range(0, 5)] = -128;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
